// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard/stall controller for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_en,
  output logic                  em_en,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic                  mw_bubble,
  output logic                  timeout_err,
  output logic [15:0]           stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign timeout_err = (state == ERROR);

  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    mw_bubble = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!rst_n) begin
      {pc_en, fd_en, de_en, em_en}    = 4'b0000;
      {fd_flush, de_bubble, mw_bubble} = 3'b111;
      state_nxt = RUN;
      wait_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            {pc_en, fd_en, de_en, em_en} = 4'b0000;
            mw_bubble = 1'b1;
            state_nxt = MEM_WAIT;
            wait_nxt  = '0;
          end else if (ex_branch_taken) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          // ack or abort lets the pipeline advance untouched; hazards are re-checked in RUN
          if (mem_ack || !mem_req) begin
            state_nxt = RUN;
          end else begin
            {pc_en, fd_en, de_en, em_en} = 4'b0000;
            mw_bubble = 1'b1;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) state_nxt = ERROR;
            else                                      wait_nxt  = wait_cnt + 1'b1;
          end
        end
        default: begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          mw_bubble = 1'b1;
          state_nxt = ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_en && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ack;
  logic        pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, mw_bubble, timeout_err;
  logic [15:0] stall_cnt;

  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .fd_flush(fd_flush), .de_bubble(de_bubble), .mw_bubble(mw_bubble),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  // Monitor: compare the DUT against the entry queued for this cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [23:0] act;
      e   = sb.pop_front();
      act = {pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, mw_bubble, timeout_err, stall_cnt};
      checks = checks + 1;
      if (act !== e.v) begin
        errors = errors + 1;
        $display("FAIL %s: got en=%b fl/db/mb=%b terr=%b cnt=%h, expected en=%b fl/db/mb=%b terr=%b cnt=%h",
                 e.name, act[23:20], act[19:17], act[16], act[15:0],
                 e.v[23:20], e.v[19:17], e.v[16], e.v[15:0]);
      end
    end
  end

  task automatic cyc(input logic rn, input logic [3:0] rs1, input logic [3:0] rs2,
                     input logic u1, input logic u2, input logic [3:0] rd,
                     input logic mr, input logic br, input logic rq, input logic ak);
    @(posedge clk);
    #1;
    rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_req = rq; mem_ack = ak;
  endtask

  task automatic idle();
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string n, input logic [3:0] en, input logic [2:0] fb,
                            input logic terr, input logic [15:0] cnt);
    exp_t e;
    e.name = n;
    e.v    = {en, fb, terr, cnt};
    sb.push_back(e);
  endtask

  initial begin
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("reset_forced", 4'b0000, 3'b111, 1'b0, 16'd0);
    idle();                                          expect_out("post_reset", 4'b1111, 3'b000, 1'b0, 16'd0);

    cyc(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("load_use_rs2", 4'b0011, 3'b010, 1'b0, 16'd0);
    idle();                                          expect_out("after_load_use", 4'b1111, 3'b000, 1'b0, 16'd1);
    cyc(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("ex_rd_zero", 4'b1111, 3'b000, 1'b0, 16'd1);
    cyc(1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("load_use_rs1", 4'b0011, 3'b010, 1'b0, 16'd1);
    cyc(1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("rs_not_used", 4'b1111, 3'b000, 1'b0, 16'd2);

    cyc(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("branch_over_load_use", 4'b1111, 3'b110, 1'b0, 16'd2);
    idle();                                          expect_out("after_branch", 4'b1111, 3'b000, 1'b0, 16'd2);

    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("mem_c0", 4'b0000, 3'b001, 1'b0, 16'd2);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("mem_c1", 4'b0000, 3'b001, 1'b0, 16'd3);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("mem_c2", 4'b0000, 3'b001, 1'b0, 16'd4);
    cyc(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_out("mem_ack_c3", 4'b1111, 3'b000, 1'b0, 16'd5);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("mem_back_run", 4'b1111, 3'b110, 1'b0, 16'd5);

    cyc(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_out("single_cycle_mem_load_use", 4'b0011, 3'b010, 1'b0, 16'd5);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("abort_c0", 4'b0000, 3'b001, 1'b0, 16'd6);
    idle();                                          expect_out("abort_release", 4'b1111, 3'b000, 1'b0, 16'd7);
    idle();                                          expect_out("abort_run", 4'b1111, 3'b000, 1'b0, 16'd7);

    for (int c = 0; c <= 16; c++) begin
      cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, (c < 16), 1'b0);
      if (c == 0)  expect_out("timeout_c0", 4'b0000, 3'b001, 1'b0, 16'd7);
      if (c == 15) expect_out("timeout_c15", 4'b0000, 3'b001, 1'b0, 16'd22);
      if (c == 16) expect_out("timeout_c16_err", 4'b0000, 3'b001, 1'b1, 16'd23);
    end
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("error_held", 4'b0000, 3'b001, 1'b1, 16'd24);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();                                          expect_out("error_cleared", 4'b1111, 3'b000, 1'b0, 16'd0);

    // Park in ERROR long enough for the stall counter to reach its ceiling
    for (int c = 0; c < 65600; c++) begin
      cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    expect_out("stall_saturated", 4'b0000, 3'b001, 1'b1, 16'hFFFF);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("stall_no_wrap", 4'b0000, 3'b001, 1'b1, 16'hFFFF);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();                                          expect_out("final_reset", 4'b1111, 3'b000, 1'b0, 16'd0);

    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
